// File: rtl/id_stage_param.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_param
// Description : Parametrised MIPS instruction-decode stage. It holds the
//               register file and decodes the control word. It detects
//               load-use hazards and resolves BEQ/BNE/J/JAL/JR/JALR
//               redirects in ID. Its registered outputs form the ID/EX
//               pipeline register.
// Ports       : i_clk/i_reset_n      clock, async active-low reset
//               i_instruction/i_pc   instruction and its PC+4 from IF/ID
//               i_valid/i_halt       IF/ID occupancy, stage freeze
//               i_wb_write_*         register-file write port from WB
//               i_ex_mem_read/i_ex_rt load currently in EX (hazard check)
//               o_stall/o_jump/o_jump_address/o_flush_if  combinational
//               o_valid, o_RA/o_RB, fields, o_inmediato, o_link,
//               o_WB_*/o_MEM_*/o_EX_*  registered ID/EX contents
// Revision    : 1.0  initial release
// ============================================================================
module id_stage_param #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PC_WIDTH   = 32,
    parameter bit WB_BYPASS  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [31:0]           i_instruction,
    input  logic [PC_WIDTH-1:0]   i_pc,
    input  logic                  i_valid,
    input  logic                  i_halt,
    input  logic                  i_wb_write_enable,
    input  logic [REG_ADDR_W-1:0] i_wb_write_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_write_data,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rt,
    output logic                  o_stall,
    output logic                  o_jump,
    output logic [PC_WIDTH-1:0]   o_jump_address,
    output logic                  o_flush_if,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_RA,
    output logic [DATA_WIDTH-1:0] o_RB,
    output logic [REG_ADDR_W-1:0] o_rs,
    output logic [REG_ADDR_W-1:0] o_rt,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [4:0]            o_shamt,
    output logic [5:0]            o_funct,
    output logic [5:0]            o_opcode,
    output logic [DATA_WIDTH-1:0] o_inmediato,
    output logic [PC_WIDTH-1:0]   o_link,
    output logic                  o_WB_mem_to_reg_ID,
    output logic                  o_WB_write_reg_ID,
    output logic                  o_MEM_mem_read_ID,
    output logic                  o_MEM_mem_write_ID,
    output logic                  o_MEM_signed_ID,
    output logic [1:0]            o_MEM_size_ID,
    output logic [1:0]            o_EX_reg_dest_ID,
    output logic [1:0]            o_EX_ALU_op_ID,
    output logic                  o_EX_ALU_src_ID
);

    localparam int         NUM_REGS = 2**REG_ADDR_W;
    localparam logic [5:0] c_FN_JR   = 6'b001000;
    localparam logic [5:0] c_FN_JALR = 6'b001001;

    // ---------------- instruction fields ----------------
    logic [5:0]            w_opcode;
    logic [5:0]            w_funct;
    logic [4:0]            w_shamt;
    logic [15:0]           w_imm16;
    logic [REG_ADDR_W-1:0] w_rs;
    logic [REG_ADDR_W-1:0] w_rt;
    logic [REG_ADDR_W-1:0] w_rd;

    assign w_opcode = i_instruction[31:26];
    assign w_funct  = i_instruction[5:0];
    assign w_shamt  = i_instruction[10:6];
    assign w_imm16  = i_instruction[15:0];
    assign w_rs     = REG_ADDR_W'(i_instruction[25:21]);
    assign w_rt     = REG_ADDR_W'(i_instruction[20:16]);
    assign w_rd     = REG_ADDR_W'(i_instruction[15:11]);

    // ---------------- register file ----------------
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wb_write_enable && (i_wb_write_addr != '0)) begin
            r_regs[i_wb_write_addr] <= i_wb_write_data;
        end
    end

    // A WB write landing this edge is forwarded to the read ports so the
    // instruction in ID sees the value it would see one cycle later.
    logic                  w_hit_rs;
    logic                  w_hit_rt;
    logic [DATA_WIDTH-1:0] w_ra;
    logic [DATA_WIDTH-1:0] w_rb;

    assign w_hit_rs = WB_BYPASS && i_wb_write_enable && (i_wb_write_addr == w_rs);
    assign w_hit_rt = WB_BYPASS && i_wb_write_enable && (i_wb_write_addr == w_rt);
    assign w_ra = (w_rs == '0) ? '0 : (w_hit_rs ? i_wb_write_data : r_regs[w_rs]);
    assign w_rb = (w_rt == '0) ? '0 : (w_hit_rt ? i_wb_write_data : r_regs[w_rt]);

    // ---------------- control decode ----------------
    // mem_to_reg = 1 selects the ALU/link result, 0 selects load data.
    logic       w_known, w_wr, w_mread, w_mwrite, w_signed, w_alu_src, w_m2r;
    logic       w_uses_rt, w_zext, w_is_beq, w_is_bne, w_is_j, w_is_jr;
    logic [1:0] w_size, w_dest, w_alu_op;

    always_comb begin
        w_known   = 1'b0;
        w_wr      = 1'b0;
        w_mread   = 1'b0;
        w_mwrite  = 1'b0;
        w_signed  = 1'b0;
        w_alu_src = 1'b0;
        w_m2r     = 1'b1;
        w_uses_rt = 1'b0;
        w_zext    = 1'b0;
        w_is_beq  = 1'b0;
        w_is_bne  = 1'b0;
        w_is_j    = 1'b0;
        w_is_jr   = 1'b0;
        w_size    = 2'd0;
        w_dest    = 2'd0;
        w_alu_op  = 2'd0;
        case (w_opcode[5:3])
            3'b000: begin
                case (w_opcode[2:0])
                    3'b000: begin                       // R-type, incl. JR/JALR
                        w_known   = 1'b1;
                        w_uses_rt = 1'b1;
                        w_alu_op  = 2'd2;
                        w_dest    = 2'd1;
                        w_wr      = (w_funct != c_FN_JR);
                        w_is_jr   = (w_funct == c_FN_JR) || (w_funct == c_FN_JALR);
                    end
                    3'b010: begin                       // J
                        w_known = 1'b1;
                        w_is_j  = 1'b1;
                    end
                    3'b011: begin                       // JAL links into r31
                        w_known = 1'b1;
                        w_is_j  = 1'b1;
                        w_wr    = 1'b1;
                        w_dest  = 2'd2;
                    end
                    3'b100, 3'b101: begin               // BEQ / BNE
                        w_known   = 1'b1;
                        w_uses_rt = 1'b1;
                        w_alu_op  = 2'd1;
                        w_is_beq  = ~w_opcode[0];
                        w_is_bne  = w_opcode[0];
                    end
                    default: ;
                endcase
            end
            3'b001: begin                               // ALU immediates
                w_known   = 1'b1;
                w_wr      = 1'b1;
                w_alu_src = 1'b1;
                w_alu_op  = 2'd3;
                w_zext    = w_opcode[2] && (w_opcode[1:0] != 2'b11);  // ANDI/ORI/XORI
            end
            3'b100: begin                               // LB LH LW LBU LHU
                if (w_opcode[2:0] inside {3'b000, 3'b001, 3'b011, 3'b100, 3'b101}) begin
                    w_known   = 1'b1;
                    w_wr      = 1'b1;
                    w_mread   = 1'b1;
                    w_m2r     = 1'b0;
                    w_alu_src = 1'b1;
                    w_signed  = ~w_opcode[2];
                    w_size    = w_opcode[1:0];
                end
            end
            3'b101: begin                               // SB SH SW
                if (w_opcode[2:0] inside {3'b000, 3'b001, 3'b011}) begin
                    w_known   = 1'b1;
                    w_mwrite  = 1'b1;
                    w_uses_rt = 1'b1;
                    w_alu_src = 1'b1;
                    w_size    = w_opcode[1:0];
                end
            end
            default: ;
        endcase
    end

    // ---------------- hazard, redirect, immediate ----------------
    logic                  w_bubble;
    logic                  w_taken;
    logic [PC_WIDTH-1:0]   w_br_off;
    logic [DATA_WIDTH-1:0] w_imm;

    assign o_stall  = i_ex_mem_read && (i_ex_rt != '0) &&
                      ((i_ex_rt == w_rs) || ((i_ex_rt == w_rt) && w_uses_rt));
    assign w_bubble = o_stall || !i_valid || (i_instruction == 32'd0) || !w_known;

    assign w_taken    = w_is_j || w_is_jr || (w_is_beq && (w_ra == w_rb)) ||
                        (w_is_bne && (w_ra != w_rb));
    assign o_jump     = w_taken && i_valid && !o_stall && !i_halt;
    assign o_flush_if = o_jump;

    assign w_br_off = {{(PC_WIDTH-18){w_imm16[15]}}, w_imm16, 2'b00};
    assign w_imm    = w_zext ? {{(DATA_WIDTH-16){1'b0}}, w_imm16}
                             : {{(DATA_WIDTH-16){w_imm16[15]}}, w_imm16};

    always_comb begin
        if (w_is_jr) begin
            o_jump_address = w_ra[PC_WIDTH-1:0];
        end else if (w_is_j) begin
            o_jump_address = {i_pc[PC_WIDTH-1:28], i_instruction[25:0], 2'b00};
        end else begin
            o_jump_address = i_pc + w_br_off;
        end
    end

    // ---------------- ID/EX register ----------------
    // Halt freezes the whole register; a bubble clears only validity and controls.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid            <= 1'b0;
            o_RA               <= '0;
            o_RB               <= '0;
            o_rs               <= '0;
            o_rt               <= '0;
            o_rd               <= '0;
            o_shamt            <= '0;
            o_funct            <= '0;
            o_opcode           <= '0;
            o_inmediato        <= '0;
            o_link             <= '0;
            o_WB_mem_to_reg_ID <= 1'b0;
            o_WB_write_reg_ID  <= 1'b0;
            o_MEM_mem_read_ID  <= 1'b0;
            o_MEM_mem_write_ID <= 1'b0;
            o_MEM_signed_ID    <= 1'b0;
            o_MEM_size_ID      <= 2'd0;
            o_EX_reg_dest_ID   <= 2'd0;
            o_EX_ALU_op_ID     <= 2'd0;
            o_EX_ALU_src_ID    <= 1'b0;
        end else if (!i_halt) begin
            o_valid            <= !w_bubble;
            o_RA               <= w_ra;
            o_RB               <= w_rb;
            o_rs               <= w_rs;
            o_rt               <= w_rt;
            o_rd               <= w_rd;
            o_shamt            <= w_shamt;
            o_funct            <= w_funct;
            o_opcode           <= w_opcode;
            o_inmediato        <= w_imm;
            o_link             <= i_pc;
            o_WB_mem_to_reg_ID <= w_m2r && !w_bubble;
            o_WB_write_reg_ID  <= w_wr && !w_bubble;
            o_MEM_mem_read_ID  <= w_mread && !w_bubble;
            o_MEM_mem_write_ID <= w_mwrite && !w_bubble;
            o_MEM_signed_ID    <= w_signed && !w_bubble;
            o_MEM_size_ID      <= w_bubble ? 2'd0 : w_size;
            o_EX_reg_dest_ID   <= w_bubble ? 2'd0 : w_dest;
            o_EX_ALU_op_ID     <= w_bubble ? 2'd0 : w_alu_op;
            o_EX_ALU_src_ID    <= w_alu_src && !w_bubble;
        end
    end

endmodule
`default_nettype wire
